// File: rtl/src_bf16_framer_if.sv
// Valid/ready word stream carrying one 32-bit word plus an end-of-frame marker.
// The producer takes the master modport, the consumer takes the slave modport.
interface src_bf16_framer_if;
  logic        valid;
  logic [31:0] data;
  logic        last;
  logic        ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/src_bf16_framer.sv
// Host fp32 stream to accelerator source stream: bf16 rounding, last regenerated
// from the frame length, and a fully registered 2-entry skid buffer between the sides.
module src_bf16_framer #(
  parameter int CW  = 12,
  parameter int FCW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [CW-1:0]        len,
  input  logic                 rnd,
  src_bf16_framer_if.slave     s,
  src_bf16_framer_if.master    m,
  output logic [FCW-1:0]       frames,
  output logic                 err,
  output logic                 busy
);

  logic            r_sReady;
  logic            r_mValid;
  logic [15:0]     r_mBf;
  logic            r_mLast;
  logic            r_skidValid;
  logic [15:0]     r_skidBf;
  logic            r_skidLast;
  logic [CW-1:0]   r_idx;
  logic [CW-1:0]   r_lenQ;
  logic [FCW-1:0]  r_frames;
  logic            r_err;
  logic            r_enD;

  logic            w_expMax;
  logic            w_manNz;
  logic            w_roundUp;
  logic [15:0]     w_bf16;
  logic [CW-1:0]   w_lenEff;
  logic            w_last;
  logic            w_accept;
  logic            w_pop;
  logic            w_outFree;
  logic [1:0]      w_occ;
  logic [1:0]      w_occNext;

  // Round-to-nearest-even on the discarded low half; NaN keeps its payload with the quiet bit set.
  always_comb begin
    w_expMax  = (s.data[30:23] == 8'hFF);
    w_manNz   = |s.data[22:0];
    w_roundUp = (s.data[15:0] > 16'h8000) ||
                ((s.data[15:0] == 16'h8000) && s.data[16]);
    w_bf16    = s.data[31:16];
    if (w_expMax && w_manNz) begin
      w_bf16 = {s.data[31:23], 1'b1, s.data[21:16]};
    end else if (!w_expMax && rnd && w_roundUp) begin
      w_bf16 = s.data[31:16] + 16'd1;
    end
  end

  always_comb begin
    w_accept  = s.valid & r_sReady;
    w_pop     = r_mValid & m.ready;
    w_outFree = ~r_mValid | m.ready;
    w_lenEff  = (r_idx == '0) ? len : r_lenQ;
    w_last    = (r_idx == w_lenEff);
    w_occ     = {1'b0, r_mValid} + {1'b0, r_skidValid};
    w_occNext = w_occ + {1'b0, w_accept} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sReady    <= 1'b0;
      r_mValid    <= 1'b0;
      r_mBf       <= '0;
      r_mLast     <= 1'b0;
      r_skidValid <= 1'b0;
      r_skidBf    <= '0;
      r_skidLast  <= 1'b0;
      r_idx       <= '0;
      r_lenQ      <= '0;
      r_frames    <= '0;
      r_err       <= 1'b0;
      r_enD       <= 1'b0;
    end else if (!en) begin
      r_sReady    <= 1'b0;
      r_mValid    <= 1'b0;
      r_skidValid <= 1'b0;
      r_idx       <= '0;
      r_enD       <= 1'b0;
    end else begin
      r_enD    <= 1'b1;
      r_sReady <= (w_occNext < 2'd2);

      // The output register refills from the skid entry first so word order is preserved.
      if (w_outFree) begin
        if (r_skidValid) begin
          r_mValid    <= 1'b1;
          r_mBf       <= r_skidBf;
          r_mLast     <= r_skidLast;
          r_skidValid <= w_accept;
        end else begin
          r_mValid <= w_accept;
          if (w_accept) begin
            r_mBf   <= w_bf16;
            r_mLast <= w_last;
          end
        end
      end else if (w_accept) begin
        r_skidValid <= 1'b1;
      end

      if (w_accept) begin
        r_skidBf   <= w_bf16;
        r_skidLast <= w_last;
        if (r_idx == '0) begin
          r_lenQ <= len;
        end
        r_idx <= w_last ? '0 : r_idx + CW'(1);
      end

      if (w_accept && (s.last != w_last)) begin
        r_err <= 1'b1;
      end else if (!r_enD) begin
        r_err <= 1'b0;
      end

      if (w_pop && r_mLast) begin
        r_frames <= r_frames + FCW'(1);
      end
    end
  end

  assign s.ready = r_sReady;
  assign m.valid = r_mValid;
  assign m.data  = {r_mBf, 16'h0000};
  assign m.last  = r_mLast;
  assign frames  = r_frames;
  assign err     = r_err;
  assign busy    = r_mValid | r_skidValid | (r_idx != '0);

endmodule

// File: doc/src_bf16_framer.md
Name: src_bf16_framer

Overview:
- Upstream stage that feeds the accelerator's source stream (src_valid/src_data/src_last/src_ready).
- Accepts a host AXI-stream of fp32 words and rounds each to bfloat16, placed in bits [31:16] with [15:0]=0.
- Regenerates last from a per-sample word count, so framing matches the sample size register.
- Buffers through a fully registered 2-entry skid buffer, so src_ready from the core never combinationally reaches the host.

Parameters:
- CW, 12, width of frame-length counter (matches ss width).
- FCW, 16, width of completed-frame counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  enable; tie to run
- len  in  CW  index of last word in a frame (frame = len+1 words); tie to ss
- rnd  in  1  1 = round-to-nearest-even, 0 = truncate
- s_valid  in  1  host word valid
- s_data  in  32  host fp32 word
- s_last  in  1  host end-of-frame marker, checked only
- s_ready  out  1  framer can accept
- m_valid  out  1  to src_valid
- m_data  out  32  to src_data; {bf16, 16'h0}
- m_last  out  1  to src_last
- m_ready  in  1  from src_ready
- frames  out  FCW  completed frames transferred on m side
- err  out  1  sticky framing mismatch
- busy  out  1  buffer non-empty or mid-frame (idx != 0)

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, frames=0, err=0, busy=0; internal idx=0 and occupancy=0.
- Handshakes:
  - Transfer on s side when s_valid & s_ready; on m side when m_valid & m_ready.
  - m_valid must not drop without a transfer, and m_data/m_last must not change while m_valid & ~m_ready, unless en falls.
- Skid buffer:
  - Occupancy is 0..2. s_ready is registered: next-cycle s_ready = en & (next occupancy < 2).
  - Latency: a word accepted in cycle N appears on m_data in cycle N+1 at the earliest.
  - Sustains 1 word/cycle when m_ready is held high.
  - Simultaneous s-accept and m-transfer leaves occupancy unchanged.
- Conversion, applied at accept and stored pre-converted:
  - Exponent field s_data[30:23]==8'hFF, mantissa nonzero (NaN): bf16 = {s_data[31:23], 1'b1, s_data[21:16]}. The quiet bit is forced to 1 regardless of rnd.
  - Exponent 8'hFF, mantissa zero (Inf): bf16 = s_data[31:16].
  - Otherwise, rnd=1: bf16 = (s_data + 32'h7FFF + s_data[16])[31:16]. Carry into the exponent is legal and may produce Inf. Denormals are rounded identically, never flushed.
  - Otherwise, rnd=0: bf16 = s_data[31:16].
- Framing:
  - len is latched into len_q on each accept with idx==0.
  - Accepted word's m_last = (idx==len_q); idx then increments, or wraps to 0 after last.
  - If s_last != computed last on any accepted word, err sets and stays set. Output last always follows the counter, never s_last.
- frames increments on each m-side transfer with m_last=1 and wraps modulo 2^FCW.
- en low:
  - Next cycle s_ready=0, m_valid=0, occupancy=0, idx=0 (buffered words are discarded).
  - frames is held.
  - err is cleared on the cycle en rises, and on reset.
- len changes mid-frame have no effect until the next frame start.
- Reset asserted mid-transfer: all state returns to reset values on the next edge, and no partial word is emitted.

Test Plan:
- rnd=1, en=1, m_ready=1: s_data 3F800000, 3F808000, 3F818000, 7F7FFFFF -> m_data 3F800000, 3F800000, 3F820000, 7F800000, each one cycle after accept.
- Special values, rnd=1: 7F800001 -> 7FC00000; FF800000 -> FF800000; 00008000 -> 00000000; 00018000 -> 00020000. With rnd=0, 3F818000 -> 3F810000.
- len=3, 12 words streamed continuously: m_last high on words 3, 7 and 11; frames reads 3; err=0; throughput 1 word/cycle.
- len=3, s_last given on word 2: err=1 from the next cycle; m_last still on word 3; err clears after en toggles 0->1.
- Backpressure: m_ready low for 5 cycles with s_valid high. s_ready falls after 2 accepts; m_data stable throughout. Words emerge in order with no loss or duplication when m_ready returns.
- en dropped with 2 words buffered and idx=2: next cycle m_valid=0, busy=0, s_ready=0. After en rises, the first accepted word starts a new frame (m_last after len+1 words).
